// File: rtl/demux1x8_tdm_pkg.sv
// ---------------------------------------------------------------------------
// demux1x8_tdm_pkg
// Shared slot definitions for the 8-slot TDM link. The mux (transmit) and
// demux (receive) sides both import this file so slot numbering cannot drift.
//   NUM_SLOTS  : slots per frame
//   SLOT_WIDTH : width of a slot index
//   SLOT_0..7  : slot index constants
//   next_slot(): modulo-8 slot increment
// ---------------------------------------------------------------------------
package demux1x8_tdm_pkg;

  localparam int NUM_SLOTS  = 8;
  localparam int SLOT_WIDTH = 3;

  typedef logic [SLOT_WIDTH-1:0] slot_t;

  localparam slot_t SLOT_0 = 3'd0;
  localparam slot_t SLOT_1 = 3'd1;
  localparam slot_t SLOT_2 = 3'd2;
  localparam slot_t SLOT_3 = 3'd3;
  localparam slot_t SLOT_4 = 3'd4;
  localparam slot_t SLOT_5 = 3'd5;
  localparam slot_t SLOT_6 = 3'd6;
  localparam slot_t SLOT_7 = 3'd7;

  // Slot 7 wraps to slot 0 through the natural 3-bit overflow.
  function automatic slot_t next_slot(input slot_t cur);
    return cur + 3'd1;
  endfunction

endpackage

// File: rtl/demux1x8.sv
// ---------------------------------------------------------------------------
// demux1x8
// Combinational 3-to-8 one-hot decode of the slot index, gated by in_valid.
// Produces the per-slot capture write enables for demux1x8_tdm.
//   slot     : current slot index
//   in_valid : a word is present this cycle
//   wr_en    : one-hot write enable (all zero when in_valid is low)
// ---------------------------------------------------------------------------
module demux1x8
  import demux1x8_tdm_pkg::*;
(
  input  logic [SLOT_WIDTH-1:0] slot,
  input  logic                  in_valid,
  output logic [NUM_SLOTS-1:0]  wr_en
);

  // One-hot slot decode, suppressed when no word is present.
  always_comb begin
    wr_en = 8'b0000_0000;
    if (in_valid) begin
      case (slot)
        SLOT_0:  wr_en = 8'b0000_0001;
        SLOT_1:  wr_en = 8'b0000_0010;
        SLOT_2:  wr_en = 8'b0000_0100;
        SLOT_3:  wr_en = 8'b0000_1000;
        SLOT_4:  wr_en = 8'b0001_0000;
        SLOT_5:  wr_en = 8'b0010_0000;
        SLOT_6:  wr_en = 8'b0100_0000;
        SLOT_7:  wr_en = 8'b1000_0000;
        default: wr_en = 8'b0000_0000;
      endcase
    end else begin
      wr_en = 8'b0000_0000;
    end
  end

endmodule

// File: rtl/demux1x8_tdm.sv
// ---------------------------------------------------------------------------
// demux1x8_tdm
// Receive side of an 8-to-1 TDM link: distributes a serial word stream onto
// eight parallel lanes, presenting each complete frame atomically.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in, in_valid   : serial word and its qualifier (no back-pressure)
//   sync           : frame start; a valid word with sync lands in slot 0
//   out_a..out_h   : last complete frame, slots 0..7
//   frame_valid    : one-cycle strobe after out_a..out_h load a new frame
//   slot           : slot the next valid word will occupy
// ---------------------------------------------------------------------------
module demux1x8_tdm
  import demux1x8_tdm_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  in_valid,
  input  logic                  sync,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [DATA_WIDTH-1:0] out_c,
  output logic [DATA_WIDTH-1:0] out_d,
  output logic [DATA_WIDTH-1:0] out_e,
  output logic [DATA_WIDTH-1:0] out_f,
  output logic [DATA_WIDTH-1:0] out_g,
  output logic [DATA_WIDTH-1:0] out_h,
  output logic                  frame_valid,
  output logic [SLOT_WIDTH-1:0] slot
);

  localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

  slot_t                 slot_r;
  logic                  frame_valid_r;
  logic [NUM_SLOTS-1:0]  dec_en_s;
  logic [NUM_SLOTS-1:0]  cap_we_s;
  logic                  complete_s;
  // Slot 7 is never stored: it goes straight from in to out_h.
  logic [DATA_WIDTH-1:0] capture_r [NUM_SLOTS-1];

  demux1x8 u_dec (
    .slot     (slot_r),
    .in_valid (in_valid),
    .wr_en    (dec_en_s)
  );

  // sync overrides the counter: a valid word goes to slot 0, nothing else is
  // written, and slot 7 can not complete a frame on that edge.
  always_comb begin
    cap_we_s = 8'b0000_0000;
    if (sync) begin
      cap_we_s[0] = in_valid;
    end else begin
      cap_we_s = dec_en_s;
    end
  end

  assign complete_s = cap_we_s[NUM_SLOTS-1];

  // Slot counter: advance on each accepted word, re-align on sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r <= SLOT_0;
    end else if (in_valid) begin
      if (sync) begin
        slot_r <= SLOT_1;
      end else begin
        slot_r <= next_slot(slot_r);
      end
    end else if (sync) begin
      slot_r <= SLOT_0;
    end else begin
      slot_r <= slot_r;
    end
  end

  // Capture registers for slots 0..6.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        capture_r[i] <= ZERO_W;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        if (cap_we_s[i]) begin
          capture_r[i] <= in;
        end
      end
    end
  end

  // Output lanes: all eight load together on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a <= ZERO_W;
      out_b <= ZERO_W;
      out_c <= ZERO_W;
      out_d <= ZERO_W;
      out_e <= ZERO_W;
      out_f <= ZERO_W;
      out_g <= ZERO_W;
      out_h <= ZERO_W;
    end else if (complete_s) begin
      out_a <= capture_r[0];
      out_b <= capture_r[1];
      out_c <= capture_r[2];
      out_d <= capture_r[3];
      out_e <= capture_r[4];
      out_f <= capture_r[5];
      out_g <= capture_r[6];
      out_h <= in;
    end
  end

  // Frame strobe: high for the one cycle after a completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_r <= 1'b0;
    end else begin
      frame_valid_r <= complete_s;
    end
  end

  assign frame_valid = frame_valid_r;
  assign slot        = slot_r;

endmodule

// File: tb/tb_demux1x8_tdm.sv
// Directed bench for demux1x8_tdm with DATA_WIDTH=8.
module tb_demux1x8_tdm;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic       in_valid;
  logic       sync;
  logic [7:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
  logic       frame_valid;
  logic [2:0] slot;

  int total;
  int bad;

  demux1x8_tdm #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .in_valid    (in_valid),
    .sync        (sync),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_d       (out_d),
    .out_e       (out_e),
    .out_f       (out_f),
    .out_g       (out_g),
    .out_h       (out_h),
    .frame_valid (frame_valid),
    .slot        (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame: lanes a..h equal w0..w7.
  task automatic chk_frame(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3, input logic [7:0] w4,
                           input logic [7:0] w5, input logic [7:0] w6, input logic [7:0] w7);
    chk({tag, ".out_a"}, {24'd0, out_a}, {24'd0, w0});
    chk({tag, ".out_b"}, {24'd0, out_b}, {24'd0, w1});
    chk({tag, ".out_c"}, {24'd0, out_c}, {24'd0, w2});
    chk({tag, ".out_d"}, {24'd0, out_d}, {24'd0, w3});
    chk({tag, ".out_e"}, {24'd0, out_e}, {24'd0, w4});
    chk({tag, ".out_f"}, {24'd0, out_f}, {24'd0, w5});
    chk({tag, ".out_g"}, {24'd0, out_g}, {24'd0, w6});
    chk({tag, ".out_h"}, {24'd0, out_h}, {24'd0, w7});
  endtask

  // One clock with a valid word; outputs are sampled 1 time unit after the edge.
  task automatic push(input logic [7:0] d, input logic s);
    in = d; in_valid = 1'b1; sync = s;
    @(posedge clk); #1;
    in_valid = 1'b0; sync = 1'b0; in = 8'h00;
  endtask

  task automatic idle(input logic s);
    in_valid = 1'b0; sync = s;
    @(posedge clk); #1;
    sync = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0; in = 8'h00; in_valid = 1'b0; sync = 1'b0;
    #12;
    chk("rst.slot", {29'd0, slot}, 32'd0);
    chk("rst.fv", {31'd0, frame_valid}, 32'd0);
    chk_frame("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk); rst_n = 1'b1;

    // Basic frame 0x10..0x17 with sync on the first word.
    push(8'h10, 1'b1);
    chk("f1.slot1", {29'd0, slot}, 32'd1);
    for (int i = 1; i < 7; i++) push(8'h10 + 8'(i), 1'b0);
    chk("f1.fv_before", {31'd0, frame_valid}, 32'd0);
    chk_frame("f1.hold", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    push(8'h17, 1'b0);
    chk("f1.fv", {31'd0, frame_valid}, 32'd1);
    chk("f1.slot", {29'd0, slot}, 32'd0);
    chk_frame("f1", 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17);
    idle(1'b0);
    chk("f1.fv_drop", {31'd0, frame_valid}, 32'd0);

    // Same words with gaps after words 2 and 5.
    push(8'h10, 1'b1);
    push(8'h11, 1'b0);
    idle(1'b0);
    chk("gap.slot", {29'd0, slot}, 32'd2);
    chk("gap.fv", {31'd0, frame_valid}, 32'd0);
    push(8'h12, 1'b0);
    push(8'h13, 1'b0);
    push(8'h14, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("gap.slot5", {29'd0, slot}, 32'd5);
    push(8'h15, 1'b0);
    push(8'h16, 1'b0);
    chk("gap.fv7", {31'd0, frame_valid}, 32'd0);
    push(8'h17, 1'b0);
    chk("gap.fv", {31'd0, frame_valid}, 32'd1);
    chk_frame("gap", 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17);

    // Frame 0x20..0x27, partial 0x30..0x34, then sync with 0x40.
    push(8'h20, 1'b1);
    for (int i = 1; i < 8; i++) push(8'h20 + 8'(i), 1'b0);
    chk("f2.fv", {31'd0, frame_valid}, 32'd1);
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 1'b0);
    chk("part.slot", {29'd0, slot}, 32'd5);
    push(8'h40, 1'b1);
    chk("resync.slot", {29'd0, slot}, 32'd1);
    chk("resync.fv", {31'd0, frame_valid}, 32'd0);
    chk_frame("resync.hold", 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27);
    for (int i = 1; i < 8; i++) push(8'h40 + 8'(i), 1'b0);
    chk("resync.fv2", {31'd0, frame_valid}, 32'd1);
    chk_frame("resync", 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47);

    // Sync with no valid word discards the partial frame.
    push(8'h50, 1'b0);
    push(8'h51, 1'b0);
    push(8'h52, 1'b0);
    idle(1'b1);
    chk("sync_only.slot", {29'd0, slot}, 32'd0);
    chk("sync_only.fv", {31'd0, frame_valid}, 32'd0);
    chk_frame("sync_only.hold", 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47);

    // Continuous 16 words: strobes only after words 8 and 16.
    for (int k = 1; k <= 16; k++) begin
      push(8'(k - 1), (k == 1) ? 1'b1 : 1'b0);
      chk($sformatf("cont.fv%0d", k), {31'd0, frame_valid}, (k == 8 || k == 16) ? 32'd1 : 32'd0);
      if (k == 8)  chk_frame("cont.a", 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
    end
    chk_frame("cont.b", 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F);

    // Asynchronous reset mid-cycle after 4 words.
    push(8'h50, 1'b1);
    for (int i = 1; i < 4; i++) push(8'h50 + 8'(i), 1'b0);
    chk("prerst.slot", {29'd0, slot}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.slot", {29'd0, slot}, 32'd0);
    chk("arst.fv", {31'd0, frame_valid}, 32'd0);
    chk_frame("arst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), 1'b0);
    chk("postrst.fv", {31'd0, frame_valid}, 32'd1);
    chk_frame("postrst", 8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67);

    // Sync with a valid word while at slot 7: re-align, no completion.
    for (int i = 0; i < 7; i++) push(8'h70 + 8'(i), 1'b0);
    chk("s7.slot7", {29'd0, slot}, 32'd7);
    push(8'h77, 1'b1);
    chk("s7.fv", {31'd0, frame_valid}, 32'd0);
    chk("s7.slot", {29'd0, slot}, 32'd1);
    chk_frame("s7.hold", 8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67);
    for (int i = 0; i < 7; i++) push(8'h78 + 8'(i), 1'b0);
    chk("s7.fv2", {31'd0, frame_valid}, 32'd1);
    chk_frame("s7", 8'h77, 8'h78, 8'h79, 8'h7A, 8'h7B, 8'h7C, 8'h7D, 8'h7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
